mmio_periph: RTL and testbench
==============================

Name: mmio_periph

Overview:
- Parametrised memory-mapped I/O block between the single-cycle CPU data port and the DRAM.
- Decodes a 4 KB I/O page and holds the 7-segment data register, the LED register, debounced switch/button inputs, a sticky button-edge register and a compare timer with interrupt.
- Gates DRAM writes so that stores to the I/O page never reach DRAM.
- Returns the read-data mux to the CPU in the same cycle.

Parameters:
- IO_BASE, 32'hFFFF_F000, base of I/O page; bits [31:12] compared.
- LED_W, 24, LED register width (1..32).
- SW_W, 24, switch input width (1..32).
- BTN_W, 5, button input width (1..32).
- DEB_CYCLES, 20000, consecutive stable cycles required to accept new switch/button value (>=2).

Ports:
- clk_i  in  1  CPU clock.
- rst_i  in  1  asynchronous active-high reset.
- we_i  in  1  CPU store enable.
- addr_i  in  32  CPU data address.
- wdata_i  in  32  CPU store data.
- mem_rdata_i  in  32  DRAM read data.
- rdata_o  out  32  read data to CPU (combinational).
- dram_we_o  out  1  DRAM write enable = we_i & ~io_hit.
- switch_i  in  SW_W  raw switches (asynchronous).
- btn_i  in  BTN_W  raw buttons (asynchronous).
- seg_data_o  out  32  7-segment display value.
- led_o  out  LED_W  LED drive.
- irq_o  out  1  timer interrupt, level.

Behaviour:
- Address decode:
  - io_hit = (addr_i[31:12] == IO_BASE[31:12]); offset = addr_i[11:0].
- Register map (offsets):
  - 0x000 SEG: RW.
  - 0x020 TCNT: RW.
  - 0x024 TCMP: RW.
  - 0x028 TCTRL: bit0 EN, bit1 AUTO, bit2 FLAG (W1C), bit3 IE.
  - 0x060 LED: RW, low LED_W bits.
  - 0x070 SW: RO, zero-extended.
  - 0x078 BTN: RO, debounced level.
  - 0x07C BTNE: sticky rising-edge bits, W1C.
- Reads:
  - rdata_o = register value when io_hit, else mem_rdata_i.
  - Unmapped I/O offsets read 0 and ignore writes. DRAM is never written for any io_hit address.
- Writes: take effect at posedge clk_i when we_i & io_hit & offset match. Readback is visible the following cycle.
- Reset (async, rst_i=1) values:
  - SEG=0, LED=0, TCNT=0, TCMP=32'hFFFF_FFFF, TCTRL=0.
  - BTNE=0, debounced SW/BTN=0, synchronisers=0, debounce counters=0.
  - Outputs: seg_data_o=0, led_o=0, irq_o=0.
  - dram_we_o stays combinational from we_i.
- Input conditioning, per group (SW, BTN):
  - Two-flop synchroniser feeding a previous-sample register.
  - If sync == debounced: counter = 0.
  - Else if sync != prev: counter = 0.
  - Else the counter increments. When it reaches DEB_CYCLES-1, debounced <= sync and counter = 0.
  - Latency from a clean input step to the register update = 2 + DEB_CYCLES cycles (±1). Glitches shorter than DEB_CYCLES never propagate.
- BTNE:
  - Bit i sets on debounced BTN[i] 0->1.
  - Writing 1 to bit i clears it. A set in the same cycle wins over the clear.
- Timer:
  - When EN=1, TCNT increments by 1 every cycle and wraps at 2^32.
  - When TCNT == TCMP with EN=1: FLAG <= 1. If AUTO=1, TCNT <= 0 next cycle instead of incrementing.
  - A CPU write to TCNT overrides increment/reload that cycle.
  - Writing TCTRL loads bits 0,1,3. Bit2=1 clears FLAG; a simultaneous match keeps FLAG=1.
  - irq_o = FLAG & IE, registered-source (no combinational path from the bus).
- Reset asserted mid-debounce or mid-count returns everything to reset values immediately. There is no partial state.

Optional Feature:
- MMIO_TIMER_EN defined: timer registers and irq_o implemented as above.
- Undefined: no timer logic. Offsets 0x020/0x024/0x028 read 0 and writes are ignored (still not forwarded to DRAM). irq_o tied 0.

Test Plan:
- Reset, then store 32'h1234_5678 to 0xFFFF_F000 and 32'h00AB_CDEF to 0xFFFF_F060 -> seg_data_o=32'h1234_5678, led_o=24'hAB_CDEF next cycle; dram_we_o=0 both cycles; readback matches.
- Store to 0x0000_4010 -> dram_we_o=1, registers unchanged; load from 0x0000_4010 -> rdata_o=mem_rdata_i. Load from 0xFFFF_F100 -> rdata_o=0.
- DEB_CYCLES=8: switch_i steps 0->24'h00_00A5 -> SW reads 0 until ~10 cycles later, then 32'h0000_00A5. A 5-cycle pulse on switch_i[0] is never seen.
- btn_i[2] held high past debounce -> BTNE=5'b00100. Write 32'h4 to 0x07C -> 0. Write 32'h4 in the same cycle a new edge arrives -> remains 5'b00100.
- MMIO_TIMER_EN: TCMP=9, TCTRL=4'b1011 -> FLAG and irq_o assert 10 cycles after enable, TCNT returns to 0 and repeats. Write TCTRL=4'b1111 -> FLAG cleared, irq_o low until the next match.
- MMIO_TIMER_EN undefined: write 0x028=32'hF -> read 0, irq_o stays 0, dram_we_o=0.

Source files
------------

// File: rtl/mmio_periph.sv
// rtl/mmio_periph.sv - I/O page decode, 7-seg/LED registers, debounced switches/buttons, optional compare timer.
// Define MMIO_TIMER_EN to build the TCNT/TCMP/TCTRL timer and irq_o; otherwise those offsets read 0.

module mmio_debounce #(
   parameter int W          = 8,
   parameter int DEB_CYCLES = 20000
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] raw_i,
   output logic [W-1:0] deb_o,
   output logic [W-1:0] rise_o
);
   localparam int            CW   = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

   logic [W-1:0]  sync1, sync2, prev, deb;
   logic [CW-1:0] cnt, cnt_inc;
   logic          settle;

   assign cnt_inc = cnt + CW'(1);
   // The whole group is accepted at once, only after sync2 stayed constant long enough.
   assign settle  = (sync2 != deb) && (sync2 == prev) && (cnt_inc == LAST);
   assign deb_o   = deb;
   assign rise_o  = settle ? (sync2 & ~deb) : '0;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
         deb   <= '0;
         cnt   <= '0;
      end else begin
         sync1 <= raw_i;
         sync2 <= sync1;
         prev  <= sync2;
         if (sync2 == deb || sync2 != prev) begin
            cnt <= '0;
         end else if (cnt_inc == LAST) begin
            deb <= sync2;
            cnt <= '0;
         end else begin
            cnt <= cnt_inc;
         end
      end
   end
endmodule

module mmio_periph #(
   parameter logic [31:0] IO_BASE    = 32'hFFFF_F000,
   parameter int          LED_W      = 24,
   parameter int          SW_W       = 24,
   parameter int          BTN_W      = 5,
   parameter int          DEB_CYCLES = 20000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic [31:0]      addr_i,
   input  logic [31:0]      wdata_i,
   input  logic [31:0]      mem_rdata_i,
   output logic [31:0]      rdata_o,
   output logic             dram_we_o,
   input  logic [SW_W-1:0]  switch_i,
   input  logic [BTN_W-1:0] btn_i,
   output logic [31:0]      seg_data_o,
   output logic [LED_W-1:0] led_o,
   output logic             irq_o
);
   localparam logic [11:0] OFF_SEG   = 12'h000;
   localparam logic [11:0] OFF_TCNT  = 12'h020;
   localparam logic [11:0] OFF_TCMP  = 12'h024;
   localparam logic [11:0] OFF_TCTRL = 12'h028;
   localparam logic [11:0] OFF_LED   = 12'h060;
   localparam logic [11:0] OFF_SW    = 12'h070;
   localparam logic [11:0] OFF_BTN   = 12'h078;
   localparam logic [11:0] OFF_BTNE  = 12'h07C;

   logic             io_hit, wr;
   logic [11:0]      offset;
   logic [31:0]      seg_q, io_rdata;
   logic [LED_W-1:0] led_q;
   logic [SW_W-1:0]  sw_deb;
   logic [SW_W-1:0]  sw_rise;
   logic [BTN_W-1:0] btn_deb, btn_rise, btne_q, btne_clr;

   assign io_hit     = (addr_i[31:12] == IO_BASE[31:12]);
   assign offset     = addr_i[11:0];
   assign wr         = we_i & io_hit;
   assign dram_we_o  = we_i & ~io_hit;
   assign seg_data_o = seg_q;
   assign led_o      = led_q;
   assign btne_clr   = (wr && offset == OFF_BTNE) ? wdata_i[BTN_W-1:0] : '0;

   mmio_debounce #(.W(SW_W), .DEB_CYCLES(DEB_CYCLES)) u_sw_deb (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .raw_i  (switch_i),
      .deb_o  (sw_deb),
      .rise_o (sw_rise)
   );

   mmio_debounce #(.W(BTN_W), .DEB_CYCLES(DEB_CYCLES)) u_btn_deb (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .raw_i  (btn_i),
      .deb_o  (btn_deb),
      .rise_o (btn_rise)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         seg_q  <= '0;
         led_q  <= '0;
         btne_q <= '0;
      end else begin
         if (wr && offset == OFF_SEG) seg_q <= wdata_i;
         if (wr && offset == OFF_LED) led_q <= wdata_i[LED_W-1:0];
         // A new edge in the same cycle as a W1C clear keeps the bit set.
         btne_q <= (btne_q & ~btne_clr) | btn_rise;
      end
   end

`ifdef MMIO_TIMER_EN
   logic [31:0] tcnt_q, tcmp_q;
   logic        en_q, auto_q, flag_q, ie_q, match;

   assign match = en_q && (tcnt_q == tcmp_q);
   assign irq_o = flag_q & ie_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tcnt_q <= '0;
         tcmp_q <= 32'hFFFF_FFFF;
         en_q   <= 1'b0;
         auto_q <= 1'b0;
         flag_q <= 1'b0;
         ie_q   <= 1'b0;
      end else begin
         if (wr && offset == OFF_TCNT)  tcnt_q <= wdata_i;
         else if (match && auto_q)      tcnt_q <= '0;
         else if (en_q)                 tcnt_q <= tcnt_q + 32'd1;
         if (wr && offset == OFF_TCMP)  tcmp_q <= wdata_i;
         if (wr && offset == OFF_TCTRL) begin
            en_q   <= wdata_i[0];
            auto_q <= wdata_i[1];
            ie_q   <= wdata_i[3];
         end
         if (match)                                           flag_q <= 1'b1;
         else if (wr && offset == OFF_TCTRL && wdata_i[2])   flag_q <= 1'b0;
      end
   end
`else
   assign irq_o = 1'b0;
`endif

   always_comb begin
      io_rdata = '0;
      case (offset)
         OFF_SEG:   io_rdata = seg_q;
`ifdef MMIO_TIMER_EN
         OFF_TCNT:  io_rdata = tcnt_q;
         OFF_TCMP:  io_rdata = tcmp_q;
         OFF_TCTRL: io_rdata = {28'd0, ie_q, flag_q, auto_q, en_q};
`endif
         OFF_LED:   io_rdata = 32'(led_q);
         OFF_SW:    io_rdata = 32'(sw_deb);
         OFF_BTN:   io_rdata = 32'(btn_deb);
         OFF_BTNE:  io_rdata = 32'(btne_q);
         default:   io_rdata = '0;
      endcase
      rdata_o = io_hit ? io_rdata : mem_rdata_i;
   end
endmodule

// File: tb/tb_mmio_periph.sv
// tb/tb_mmio_periph.sv - randomized self-checking bench for mmio_periph (timer checks when MMIO_TIMER_EN is defined).

module tb_mmio_periph;
   localparam int DEB = 8;
   localparam logic [31:0] A_SEG   = 32'hFFFF_F000;
   localparam logic [31:0] A_TCNT  = 32'hFFFF_F020;
   localparam logic [31:0] A_TCMP  = 32'hFFFF_F024;
   localparam logic [31:0] A_TCTRL = 32'hFFFF_F028;
   localparam logic [31:0] A_LED   = 32'hFFFF_F060;
   localparam logic [31:0] A_SW    = 32'hFFFF_F070;
   localparam logic [31:0] A_BTN   = 32'hFFFF_F078;
   localparam logic [31:0] A_BTNE  = 32'hFFFF_F07C;

   logic        clk = 1'b0, rst = 1'b0, we = 1'b0;
   logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
   logic [23:0] switch_in = '0;
   logic [4:0]  btn_in = '0;
   logic [31:0] rdata, seg_data;
   logic        dram_we, irq;
   logic [23:0] led;

   int n_tests = 0, n_fail = 0;
   logic [31:0] m_seg = '0;
   logic [23:0] m_led = '0;

   mmio_periph #(.DEB_CYCLES(DEB)) dut (
      .clk_i(clk), .rst_i(rst), .we_i(we), .addr_i(addr), .wdata_i(wdata),
      .mem_rdata_i(mem_rdata), .rdata_o(rdata), .dram_we_o(dram_we),
      .switch_i(switch_in), .btn_i(btn_in), .seg_data_o(seg_data), .led_o(led), .irq_o(irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      we = 1'b1; addr = a; wdata = d;
      #1;
      n_tests++; if (dram_we !== 1'b0) begin n_fail++; $display("FAIL io_write_dram_we addr=%h got %b exp 0", a, dram_we); end
      tick();
      we = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      we = 1'b0; addr = a;
      #1;
      d = rdata;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      #2 rst = 1'b1;
      #1;
      n_tests++; if (seg_data !== 32'h0) begin n_fail++; $display("FAIL reset_seg got %h exp 0", seg_data); end
      n_tests++; if (led !== 24'h0) begin n_fail++; $display("FAIL reset_led got %h exp 0", led); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", irq); end
      bus_read(A_SW, d);
      n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_sw got %h exp 0", d); end
      bus_read(A_BTNE, d);
      n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_btne got %h exp 0", d); end
`ifdef MMIO_TIMER_EN
      bus_read(A_TCMP, d);
      n_tests++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_tcmp got %h exp ffffffff", d); end
`endif
      we = 1'b1; addr = 32'h0000_4000;
      #1;
      n_tests++; if (dram_we !== 1'b1) begin n_fail++; $display("FAIL reset_dram_we got %b exp 1", dram_we); end
      we = 1'b0;
      @(negedge clk) rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_rw();
      logic [31:0] d, s, l;
      for (int i = 0; i < 5; i++) begin
         s = (i == 0) ? 32'h1234_5678 : $urandom;
         l = (i == 0) ? 32'h00AB_CDEF : $urandom;
         bus_write(A_SEG, s);
         bus_write(A_LED, l);
         m_seg = s; m_led = l[23:0];
         n_tests++; if (seg_data !== m_seg) begin n_fail++; $display("FAIL seg_out got %h exp %h", seg_data, m_seg); end
         n_tests++; if (led !== m_led) begin n_fail++; $display("FAIL led_out got %h exp %h", led, m_led); end
         bus_read(A_SEG, d);
         n_tests++; if (d !== m_seg) begin n_fail++; $display("FAIL seg_readback got %h exp %h", d, m_seg); end
         bus_read(A_LED, d);
         n_tests++; if (d !== {8'h0, m_led}) begin n_fail++; $display("FAIL led_readback got %h exp %h", d, {8'h0, m_led}); end
      end
   endtask

   task automatic test_dram_pass();
      logic [31:0] d, a;
      logic exp_we;
      we = 1'b1; addr = 32'h0000_4010; wdata = $urandom;
      #1;
      n_tests++; if (dram_we !== 1'b1) begin n_fail++; $display("FAIL dram_store_we got %b exp 1", dram_we); end
      tick();
      we = 1'b0;
      n_tests++; if (seg_data !== m_seg || led !== m_led) begin n_fail++; $display("FAIL dram_store_regs seg=%h led=%h exp %h %h", seg_data, led, m_seg, m_led); end
      mem_rdata = $urandom | 32'h1;
      bus_read(32'h0000_4010, d);
      n_tests++; if (d !== mem_rdata) begin n_fail++; $display("FAIL dram_load got %h exp %h", d, mem_rdata); end
      bus_read(32'hFFFF_F100, d);
      n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got %h exp 0", d); end
      bus_write(32'hFFFF_F0A4, $urandom);
      bus_read(32'hFFFF_F0A4, d);
      n_tests++; if (d !== 32'h0 || seg_data !== m_seg) begin n_fail++; $display("FAIL unmapped_write rd=%h seg=%h exp 0 %h", d, seg_data, m_seg); end
      for (int i = 0; i < 8; i++) begin
         tick();
         a = $urandom;
         if (i[0]) a[31:12] = 20'hFFFFF;
         exp_we = (a[31:12] != 20'hFFFFF);
         mem_rdata = $urandom;
         we = 1'b1; addr = a;
         #1;
         n_tests++; if (dram_we !== exp_we) begin n_fail++; $display("FAIL rand_dram_we addr=%h got %b exp %b", a, dram_we, exp_we); end
         we = 1'b0;
         #1;
         if (exp_we) begin
            n_tests++; if (rdata !== mem_rdata) begin n_fail++; $display("FAIL rand_mem_rdata addr=%h got %h exp %h", a, rdata, mem_rdata); end
         end
      end
   endtask

   task automatic test_switch_debounce();
      logic [31:0] d;
      logic [23:0] val;
      int glen;
      val = 24'h0000A5;
      for (int pass = 0; pass < 2; pass++) begin
         logic [23:0] old;
         old = (pass == 0) ? 24'h0 : 24'h0000A5;
         if (pass == 1) val = $urandom | 24'h1;
         switch_in = val;
         // Accepted no earlier than DEB cycles and no later than DEB+3 cycles after the step.
         for (int k = 1; k <= DEB + 6; k++) begin
            tick();
            bus_read(A_SW, d);
            if (k <= DEB) begin
               n_tests++; if (d !== {8'h0, old}) begin n_fail++; $display("FAIL sw_early k=%0d got %h exp %h", k, d, {8'h0, old}); end
            end else if (k >= DEB + 3) begin
               n_tests++; if (d !== {8'h0, val}) begin n_fail++; $display("FAIL sw_settled k=%0d got %h exp %h", k, d, {8'h0, val}); end
            end
         end
      end
      for (int g = 0; g < 3; g++) begin
         glen = (g == 0) ? 5 : (g == 1) ? DEB - 1 : $urandom_range(1, DEB - 1);
         switch_in = val ^ 24'h1;
         repeat (glen) tick();
         switch_in = val;
         for (int k = 0; k < 2 * DEB; k++) begin
            tick();
            bus_read(A_SW, d);
            n_tests++; if (d !== {8'h0, val}) begin n_fail++; $display("FAIL sw_glitch len=%0d got %h exp %h", glen, d, {8'h0, val}); end
         end
      end
   endtask

   task automatic test_button_edges();
      logic [31:0] d;
      logic [4:0] m, c;
      btn_in = 5'b00100;
      repeat (DEB + 6) tick();
      bus_read(A_BTN, d);
      n_tests++; if (d !== 32'h4) begin n_fail++; $display("FAIL btn_level got %h exp 4", d); end
      bus_read(A_BTNE, d);
      n_tests++; if (d !== 32'h4) begin n_fail++; $display("FAIL btne_set got %h exp 4", d); end
      bus_write(A_BTNE, 32'h4);
      bus_read(A_BTNE, d);
      n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL btne_clear got %h exp 0", d); end
      btn_in = 5'b0;
      repeat (DEB + 6) tick();
      bus_read(A_BTNE, d);
      n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL btne_fall got %h exp 0", d); end
      // Clear is written every cycle up to and including the cycle the debounced edge lands.
      btn_in = 5'b00100;
      for (int k = 1; k <= DEB + 2; k++) bus_write(A_BTNE, 32'h4);
      bus_read(A_BTNE, d);
      n_tests++; if (d !== 32'h4) begin n_fail++; $display("FAIL btne_set_wins got %h exp 4", d); end
      btn_in = 5'b0;
      repeat (DEB + 6) tick();
      bus_write(A_BTNE, 32'h1F);
      for (int r = 0; r < 3; r++) begin
         m = $urandom_range(1, 31);
         c = $urandom;
         btn_in = m;
         repeat (DEB + 6) tick();
         bus_read(A_BTN, d);
         n_tests++; if (d !== {27'h0, m}) begin n_fail++; $display("FAIL btn_rand_level got %h exp %h", d, m); end
         bus_write(A_BTNE, {27'h0, c});
         bus_read(A_BTNE, d);
         n_tests++; if (d !== {27'h0, m & ~c}) begin n_fail++; $display("FAIL btne_rand got %h exp %h", d, m & ~c); end
         btn_in = 5'b0;
         repeat (DEB + 6) tick();
         bus_write(A_BTNE, 32'h1F);
      end
   endtask

`ifdef MMIO_TIMER_EN
   task automatic run_auto(input int p);
      logic [31:0] d;
      int last_clr;
      bit cleared;
      logic exp_flag;
      bus_write(A_TCTRL, 32'h4);
      bus_write(A_TCTRL, 32'h4);
      bus_write(A_TCMP, p - 1);
      bus_write(A_TCNT, 32'h0);
      bus_write(A_TCTRL, 32'hB);
      bus_read(A_TCNT, d);
      n_tests++; if (d !== 32'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL tmr_start tcnt=%h irq=%b exp 0 0", d, irq); end
      last_clr = 0; cleared = 0;
      for (int c = 1; c <= 3 * p + 2; c++) begin
         if (!cleared && c > p + 1 && (c % p) == 1) begin
            bus_write(A_TCTRL, 32'hF);
            cleared = 1; last_clr = c;
            bus_read(A_TCTRL, d);
            n_tests++; if (d !== 32'hB) begin n_fail++; $display("FAIL tmr_tctrl_clr got %h exp b", d); end
         end else begin
            tick();
         end
         exp_flag = (c / p) > (last_clr / p);
         bus_read(A_TCNT, d);
         n_tests++; if (d !== 32'(c % p)) begin n_fail++; $display("FAIL tmr_tcnt p=%0d c=%0d got %h exp %h", p, c, d, c % p); end
         n_tests++; if (irq !== exp_flag) begin n_fail++; $display("FAIL tmr_irq p=%0d c=%0d got %b exp %b", p, c, irq, exp_flag); end
      end
      bus_write(A_TCTRL, 32'h4);
      bus_write(A_TCTRL, 32'h4);
   endtask

   task automatic test_timer();
      logic [31:0] d;
      run_auto(10);
      run_auto($urandom_range(3, 12));
      bus_write(A_TCMP, 32'd5);
      bus_write(A_TCNT, 32'd100);
      repeat (3) tick();
      bus_read(A_TCNT, d);
      n_tests++; if (d !== 32'd100) begin n_fail++; $display("FAIL tmr_hold got %h exp 64", d); end
      bus_write(A_TCTRL, 32'h1);
      tick();
      bus_read(A_TCNT, d);
      n_tests++; if (d !== 32'd101) begin n_fail++; $display("FAIL tmr_run got %h exp 65", d); end
      bus_write(A_TCNT, 32'hFFFF_FFFE);
      for (int k = 0; k < 3; k++) begin
         logic [31:0] e;
         tick();
         e = 32'hFFFF_FFFF + k;
         bus_read(A_TCNT, d);
         n_tests++; if (d !== e) begin n_fail++; $display("FAIL tmr_wrap k=%0d got %h exp %h", k, d, e); end
      end
      bus_write(A_TCTRL, 32'h9);
      bus_write(A_TCNT, 32'h0);
      for (int c = 1; c <= 8; c++) begin
         tick();
         bus_read(A_TCNT, d);
         n_tests++; if (d !== 32'(c)) begin n_fail++; $display("FAIL tmr_noauto_tcnt c=%0d got %h exp %h", c, d, c); end
         n_tests++; if (irq !== (c >= 6)) begin n_fail++; $display("FAIL tmr_noauto_irq c=%0d got %b exp %b", c, irq, c >= 6); end
      end
      bus_write(A_TCTRL, 32'h4);
      bus_write(A_TCTRL, 32'h4);
   endtask
`else
   task automatic test_timer_absent();
      logic [31:0] d;
      bus_write(A_TCTRL, 32'hF);
      bus_write(A_TCNT, 32'h5);
      bus_write(A_TCMP, 32'h3);
      bus_read(A_TCTRL, d);
      n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL notmr_tctrl got %h exp 0", d); end
      bus_read(A_TCNT, d);
      n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL notmr_tcnt got %h exp 0", d); end
      bus_read(A_TCMP, d);
      n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL notmr_tcmp got %h exp 0", d); end
      for (int k = 0; k < 12; k++) begin
         tick();
         n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL notmr_irq k=%0d got %b exp 0", k, irq); end
      end
   endtask
`endif

   task automatic test_async_reset();
      logic [31:0] d;
      bus_write(A_SEG, $urandom | 32'h1);
      bus_write(A_LED, $urandom | 32'h1);
`ifdef MMIO_TIMER_EN
      bus_write(A_TCMP, $urandom);
      bus_write(A_TCTRL, 32'h1);
`endif
      switch_in = 24'h5A5A5A;
      repeat (DEB / 2 + 2) tick();
      @(negedge clk) rst = 1'b1;
      #1;
      m_seg = '0; m_led = '0;
      n_tests++; if (seg_data !== 32'h0 || led !== 24'h0) begin n_fail++; $display("FAIL async_rst_out seg=%h led=%h exp 0 0", seg_data, led); end
      bus_read(A_SW, d);
      n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL async_rst_sw got %h exp 0", d); end
`ifdef MMIO_TIMER_EN
      bus_read(A_TCNT, d);
      n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL async_rst_tcnt got %h exp 0", d); end
      bus_read(A_TCMP, d);
      n_tests++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL async_rst_tcmp got %h exp ffffffff", d); end
      bus_read(A_TCTRL, d);
      n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL async_rst_tctrl got %h exp 0", d); end
`endif
      switch_in = '0;
      @(negedge clk) rst = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic_rw();
      test_dram_pass();
      test_switch_debounce();
      test_button_edges();
`ifdef MMIO_TIMER_EN
      test_timer();
`else
      test_timer_absent();
`endif
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
